// File: rtl/regfile.sv
// regfile: 2**ADDR_W x WIDTH register bank with two combinational read ports
// and one synchronous write port. Register 0 always reads as zero.
module regfile #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we3,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [WIDTH-1:0]  wd3,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2
);

    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic             w_wr_en;
    logic             w_a1_zero;
    logic             w_a2_zero;

    // Writes to register 0 are dropped so it never holds anything but zero
    assign w_wr_en   = we3 && (a3 != '0);
    assign w_a1_zero = (a1 == '0);
    assign w_a2_zero = (a2 == '0);

    // Storage update: synchronous clear has priority over the write port
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[a3] <= wd3;
        end
    end

    // Combinational read ports; address 0 is forced to zero independent of storage
    always_comb begin
        rd1 = w_a1_zero ? '0 : r_regs[a1];
        rd2 = w_a2_zero ? '0 : r_regs[a2];
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// checked against an array model of the register bank.
module tb_regfile;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              we3;
    logic [ADDR_W-1:0] a1, a2, a3;
    logic [WIDTH-1:0]  wd3;
    logic [WIDTH-1:0]  rd1, rd2;

    logic [WIDTH-1:0]  model [NREGS];
    int                checks   = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    regfile #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .reset(reset),
        .we3  (we3),
        .a1   (a1),
        .a2   (a2),
        .a3   (a3),
        .wd3  (wd3),
        .rd1  (rd1),
        .rd2  (rd2)
    );

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                            input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        return (a == '0) ? '0 : model[a];
    endfunction

    task automatic check_reads(input string tag);
        check_eq({tag, "_rd1"}, rd1, exp_rd(a1));
        check_eq({tag, "_rd2"}, rd2, exp_rd(a2));
    endtask

    // One rising edge; the model applies the rules using the values sampled there
    task automatic clock_edge();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) model[i] = '0;
        end else if (we3 && a3 != '0) begin
            model[a3] = wd3;
        end
        #1;
    endtask

    task automatic drive(input logic rst, input logic we, input logic [ADDR_W-1:0] wa,
                         input logic [WIDTH-1:0] wd, input logic [ADDR_W-1:0] ra1,
                         input logic [ADDR_W-1:0] ra2);
        @(negedge clk);
        reset = rst; we3 = we; a3 = wa; wd3 = wd; a1 = ra1; a2 = ra2;
        #1;
    endtask

    initial begin
        reset = 1'b1; we3 = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
        for (int i = 0; i < int'(NREGS); i++) model[i] = 'x;

        // Reset, then read
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
        clock_edge();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd31);
        check_eq("rst_rd1", rd1, 32'h0);
        check_eq("rst_rd2", rd2, 32'h0);
        for (int i = 0; i < int'(NREGS); i++) begin
            a1 = ADDR_W'(i); a2 = ADDR_W'(NREGS - 1 - i);
            #1;
            check_reads("rst_sweep");
        end

        // Single write to register 9; old value before the edge, new after
        drive(1'b0, 1'b1, 5'd9, 32'h1, 5'd9, 5'd31);
        check_eq("w9_pre", rd1, 32'h0);
        clock_edge();
        check_eq("w9_post", rd1, 32'h1);

        // Second port, distinct register
        drive(1'b0, 1'b1, 5'd31, 32'h3, 5'd9, 5'd31);
        check_eq("w31_pre", rd2, 32'h0);
        clock_edge();
        check_eq("w31_rd2", rd2, 32'h3);
        check_eq("w31_rd1", rd1, 32'h1);

        // Overwrite register 9, both ports on the same register
        drive(1'b0, 1'b1, 5'd9, 32'd123, 5'd9, 5'd9);
        clock_edge();
        check_eq("ow_rd1", rd1, 32'h7B);
        check_eq("ow_rd2", rd2, 32'h7B);
        a2 = 5'd31; #1;
        check_eq("ow_r31", rd2, 32'h3);

        // Register 0 ignores writes
        drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        clock_edge();
        check_eq("r0_rd1", rd1, 32'h0);
        check_eq("r0_rd2", rd2, 32'h0);

        // we3 low writes nothing
        drive(1'b0, 1'b0, 5'd5, 32'hA5A5_A5A5, 5'd5, 5'd9);
        clock_edge();
        check_eq("we0_r5", rd1, 32'h0);
        check_eq("we0_r9", rd2, 32'h7B);

        // A we3 pulse between edges writes nothing
        drive(1'b0, 1'b0, 5'd12, 32'hDEAD_BEEF, 5'd12, 5'd31);
        we3 = 1'b1; #2; we3 = 1'b0;
        clock_edge();
        check_eq("glitch_r12", rd1, 32'h0);

        // Reset beats a same-edge write and clears earlier contents
        drive(1'b1, 1'b1, 5'd7, 32'h1234, 5'd7, 5'd9);
        clock_edge();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd9);
        check_eq("rp_r7", rd1, 32'h0);
        check_eq("rp_r9", rd2, 32'h0);
        a1 = 5'd31; #1;
        check_eq("rp_r31", rd1, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [ADDR_W-1:0] wa;
            wa = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(0, NREGS - 1));
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), wa,
                  WIDTH'($urandom()),
                  ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, NREGS - 1)),
                  ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, NREGS - 1)));
            check_reads("rnd_pre");
            clock_edge();
            check_reads("rnd_post");
            a1 = ADDR_W'($urandom_range(0, NREGS - 1));
            a2 = ADDR_W'($urandom_range(0, NREGS - 1));
            #1;
            check_reads("rnd_addr");
        end

        // Final sweep of the whole bank
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < int'(NREGS); i++) begin
            a1 = ADDR_W'(i); a2 = ADDR_W'(i);
            #1;
            check_reads("final");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
Three-port register file: 32 registers of 32 bits each, with two asynchronous read ports and one synchronous write port. It serves as the general-purpose register bank of the processor datapath. Register 0 is hardwired to zero.

Parameters:
- WIDTH, 32, data width of each register in bits
- ADDR_W, 5, address width; number of registers is 2**ADDR_W (32)

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high; clears all registers
- we3  input  1  write enable for write port 3
- a1  input  ADDR_W  read address, port 1
- a2  input  ADDR_W  read address, port 2
- a3  input  ADDR_W  write address, port 3
- wd3  input  WIDTH  write data, port 3
- rd1  output  WIDTH  read data, port 1
- rd2  output  WIDTH  read data, port 2

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Storage: 2**ADDR_W registers, each WIDTH bits wide.
- Reset:
  - On a rising clk edge with reset=1, every register becomes 0.
  - Reset has priority over a write in the same cycle.
  - After reset, rd1 and rd2 read 0 for every address.
- Write:
  - On a rising clk edge with reset=0 and we3=1, register[a3] takes wd3.
  - With we3=0, no register changes.
  - The write is visible on the read ports immediately after that edge (zero-cycle latency after the edge).
- Register 0:
  - Writes to a3=0 are ignored.
  - rd1=0 whenever a1=0, and rd2=0 whenever a2=0, regardless of history.
- Read:
  - Purely combinational: rd1=register[a1] and rd2=register[a2], updating whenever the address or the register contents change.
  - No clock latency.
- Both read ports are independent: they may address the same register or different registers simultaneously.
- Same-cycle read of the address being written: the read returns the old value before the edge and the new value after it. There is no internal write-to-read bypass.
- All address values are in range; there is no error condition.
- Register contents before the first reset are undefined.
  - Verification must apply reset before checking any data.
  - Once reset, unwritten registers read 0.
- Changes to we3, a3 or wd3 between edges have no effect.
  - Only values sampled at the rising edge matter.
  - A we3 pulse that does not span a rising edge writes nothing.

Test Plan:
- Reset, then read: assert reset for one edge; set a1=9, a2=31 -> rd1=0, rd2=0.
- Single write: we3=1, a3=9, wd3=1 for one edge, then we3=0; a1=9 -> rd1=0x00000001; before the edge rd1=0.
- Second port, distinct register: a2=31 reads 0; write a3=31, wd3=3 -> rd2=0x00000003; rd1 at a1=9 still 0x00000001.
- Overwrite: a2=9; write a3=9, wd3=123 -> rd2=0x0000007B and rd1 (a1=9)=0x0000007B on both ports simultaneously; register 31 unchanged at 3.
- Register 0 and we3 gating:
  - Write a3=0, wd3=0xFFFFFFFF -> rd1 (a1=0)=0.
  - Write a3=5, wd3=0xA5A5A5A5 with we3=0 -> register 5 reads 0.
- Reset priority: reset=1 and we3=1, a3=7, wd3=0x1234 on the same edge -> register 7=0; all earlier values (9, 31) cleared to 0.
